// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU (A) and load (B) write-back paths, with an in-flight write scoreboard.
module reg_write_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int ZERO_REG   = 31,
    parameter int ZERO_DROP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    output logic              pend_1,
    output logic              pend_2,
    output logic              idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ZREG = ADDR_W'(ZERO_REG);
    localparam logic DROP_EN = (ZERO_DROP != 0);

    logic [ADDR_W-1:0] dest_q [2][FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [2][FIFO_DEPTH];
    logic [PW:0]       wptr_q [2];
    logic [PW:0]       rptr_q [2];
    logic [PW:0]       cnt    [2];
    logic              rr_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] reg_write_dest_q;
    logic [DATA_W-1:0] reg_write_data_q;

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_dest [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        nonempty;
    logic [1:0]        full;
    logic [1:0]        push;
    logic [1:0]        gnt;
    logic              gs;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              drop;
    logic [FIFO_DEPTH-1:0] live [2];
    logic [PW-1:0]     off    [2][FIFO_DEPTH];

    assign in_valid   = {b_valid, a_valid};
    assign in_dest[0] = a_dest;
    assign in_dest[1] = b_dest;
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (wptr_q[s] != rptr_q[s]);
            full[s] = (wptr_q[s][PW] != rptr_q[s][PW]) &&
                      (wptr_q[s][PW-1:0] == rptr_q[s][PW-1:0]);
            push[s] = in_valid[s] && !full[s];
            cnt[s] = wptr_q[s] - rptr_q[s];
        end
    end

    assign a_ready = !full[0];
    assign b_ready = !full[1];

    // Round-robin only matters when both sides have work queued.
    assign gnt[0] = nonempty[0] && (!nonempty[1] || !rr_q);
    assign gnt[1] = nonempty[1] && (!nonempty[0] || rr_q);
    assign gs        = gnt[1];
    assign head_dest = dest_q[gs][rptr_q[gs][PW-1:0]];
    assign head_data = data_q[gs][rptr_q[gs][PW-1:0]];
    assign drop      = DROP_EN && (head_dest == ZREG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            rr_q             <= 1'b0;
            reg_write_q      <= 1'b0;
            reg_write_dest_q <= '0;
            reg_write_data_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wptr_q[s] <= wptr_q[s] + (PW+1)'(1);
                if (gnt[s])  rptr_q[s] <= rptr_q[s] + (PW+1)'(1);
            end
            if (|gnt) begin
                rr_q             <= ~gs;
                reg_write_dest_q <= head_dest;
                reg_write_data_q <= head_data;
            end
            reg_write_q <= (|gnt) && !drop;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                dest_q[s][wptr_q[s][PW-1:0]] <= in_dest[s];
                data_q[s][wptr_q[s][PW-1:0]] <= in_data[s];
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                off[s][i] = PW'(i) - rptr_q[s][PW-1:0];
                live[s][i] = ({1'b0, off[s][i]} < cnt[s]) &&
                             !(DROP_EN && dest_q[s][i] == ZREG);
            end
        end
    end

    always_comb begin
        pend_1 = reg_write_q && (reg_write_dest_q == reg_read_addr_1);
        pend_2 = reg_write_q && (reg_write_dest_q == reg_read_addr_2);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (live[s][i] && dest_q[s][i] == reg_read_addr_1) pend_1 = 1'b1;
                if (live[s][i] && dest_q[s][i] == reg_read_addr_2) pend_2 = 1'b1;
            end
        end
    end

    assign idle           = !nonempty[0] && !nonempty[1] && !reg_write_q;
    assign reg_write      = reg_write_q;
    assign reg_write_dest = reg_write_dest_q;
    assign reg_write_data = reg_write_data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected writes are queued at
// stimulus time and checked by a monitor whenever reg_write is high.
module tb_reg_write_arbiter;
    typedef struct packed {
        logic [4:0]  dest;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_dest, b_dest;
    logic [63:0] a_data, b_data;
    logic        reg_write;
    logic [4:0]  reg_write_dest;
    logic [63:0] reg_write_data;
    logic [4:0]  reg_read_addr_1, reg_read_addr_2;
    logic        pend_1, pend_2, idle;

    int  n_chk = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    reg_write_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_dest(b_dest), .b_data(b_data),
        .reg_write(reg_write),
        .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data),
        .reg_read_addr_1(reg_read_addr_1),
        .reg_read_addr_2(reg_read_addr_2),
        .pend_1(pend_1), .pend_2(pend_2), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [63:0] v);
        wr_t e;
        e.dest = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic send_a(input logic [4:0] d, input logic [63:0] v);
        bit ok = 0;
        a_valid = 1; a_dest = d; a_data = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = a_ready;
            tick();
        end
        a_valid = 0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_a timeout dest %0d", d);
        end
    endtask

    task automatic send_b(input logic [4:0] d, input logic [63:0] v);
        bit ok = 0;
        b_valid = 1; b_dest = d; b_data = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = b_ready;
            tick();
        end
        b_valid = 0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_b timeout dest %0d", d);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        reset = 1;
    endtask

    always @(negedge clk) begin
        if (reset && reg_write) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_wr: got dest %0d data %0h want none",
                         reg_write_dest, reg_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_dest", 64'(reg_write_dest), 64'(mon_e.dest));
                chk("wb_data", reg_write_data, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        a_valid = 0; a_dest = 0; a_data = 0;
        b_valid = 0; b_dest = 0; b_data = 0;
        reg_read_addr_1 = 0; reg_read_addr_2 = 0;
        #2;
        chk("rst_rw", 64'(reg_write), 0);
        chk("rst_dest", 64'(reg_write_dest), 0);
        chk("rst_data", reg_write_data, 0);
        chk("rst_ardy", 64'(a_ready), 1);
        chk("rst_brdy", 64'(b_ready), 1);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_pend", 64'({pend_1, pend_2}), 0);
        tick();
        tick();
        reset = 1;

        // Queue entries, then reset before anything reaches the monitor.
        a_valid = 1; a_dest = 10; a_data = 64'h11;
        b_valid = 1; b_dest = 11; b_data = 64'h22;
        tick();
        tick();
        chk("pre_rst_bfull", 64'(b_ready), 0);
        reset = 0;
        a_valid = 0; b_valid = 0;
        #1;
        chk("mid_rst_rw", 64'(reg_write), 0);
        chk("mid_rst_data", reg_write_data, 0);
        tick();
        reset = 1;
        tick();
        chk("post_rst_rw", 64'(reg_write), 0);
        chk("post_rst_dest", 64'(reg_write_dest), 0);
        chk("post_rst_rdy", 64'({a_ready, b_ready}), 3);
        chk("post_rst_idle", 64'(idle), 1);
        repeat (4) tick();

        // Single write with scoreboard pending window.
        reg_read_addr_1 = 7;
        expect_wr(7, 64'd916);
        a_valid = 1; a_dest = 7; a_data = 64'd916;
        tick();
        a_valid = 0;
        chk("s_rw_e1", 64'(reg_write), 0);
        chk("s_pend_e1", 64'(pend_1), 1);
        tick();
        chk("s_rw_e2", 64'(reg_write), 1);
        chk("s_dest_e2", 64'(reg_write_dest), 7);
        chk("s_data_e2", reg_write_data, 64'h394);
        chk("s_pend_e2", 64'(pend_1), 1);
        tick();
        chk("s_rw_e3", 64'(reg_write), 0);
        chk("s_pend_e3", 64'(pend_1), 0);
        chk("s_idle_e3", 64'(idle), 1);

        // Both saturated: alternating grants, backpressure on full FIFOs.
        do_reset();
        expect_wr(1, 64'd101); expect_wr(4, 64'd204);
        expect_wr(2, 64'd102); expect_wr(5, 64'd205);
        expect_wr(3, 64'd103); expect_wr(6, 64'd206);
        fork
            begin
                send_a(1, 64'd101); send_a(2, 64'd102); send_a(3, 64'd103);
            end
            begin
                send_b(4, 64'd204); send_b(5, 64'd205); send_b(6, 64'd206);
            end
            begin
                tick();
                chk("sat_rw_e1", 64'(reg_write), 0);
                tick();
                chk("sat_bfull_e2", 64'(b_ready), 0);
                chk("sat_rw_e2", 64'(reg_write), 1);
                tick();
                chk("sat_brdy_e3", 64'(b_ready), 1);
                chk("sat_afull_e3", 64'(a_ready), 0);
                chk("sat_rw_e3", 64'(reg_write), 1);
                for (int e = 4; e <= 7; e++) begin
                    tick();
                    chk($sformatf("sat_rw_e%0d", e), 64'(reg_write), 1);
                end
                tick();
                chk("sat_rw_e8", 64'(reg_write), 0);
            end
        join
        repeat (2) tick();

        // A floods first, then B delivers a back-to-back burst.
        expect_wr(8, 64'h8); expect_wr(9, 64'h9); expect_wr(10, 64'hA);
        expect_wr(12, 64'hC); expect_wr(13, 64'hD);
        send_a(8, 64'h8); send_a(9, 64'h9); send_a(10, 64'hA);
        send_b(12, 64'hC); send_b(13, 64'hD);
        chk("burst_rw", 64'(reg_write), 1);
        tick();
        chk("burst_rw2", 64'(reg_write), 1);
        repeat (2) tick();

        // Writes to the zero register are swallowed.
        reg_read_addr_1 = 31;
        send_a(31, 64'hFFFF);
        chk("z_pend", 64'(pend_1), 0);
        chk("z_idle_e1", 64'(idle), 0);
        tick();
        chk("z_rw", 64'(reg_write), 0);
        chk("z_idle", 64'(idle), 1);

        // Same destination from both sides: A first, B's data lands last.
        do_reset();
        reg_read_addr_2 = 5;
        expect_wr(5, 64'hAAAA);
        expect_wr(5, 64'hBBBB);
        a_valid = 1; a_dest = 5; a_data = 64'hAAAA;
        b_valid = 1; b_dest = 5; b_data = 64'hBBBB;
        tick();
        a_valid = 0; b_valid = 0;
        chk("dup_pend_e1", 64'(pend_2), 1);
        tick();
        chk("dup_data_e2", reg_write_data, 64'hAAAA);
        chk("dup_pend_e2", 64'(pend_2), 1);
        tick();
        chk("dup_data_e3", reg_write_data, 64'hBBBB);
        chk("dup_rw_e3", 64'(reg_write), 1);
        chk("dup_pend_e3", 64'(pend_2), 1);
        tick();
        chk("dup_rw_e4", 64'(reg_write), 0);
        chk("dup_pend_e4", 64'(pend_2), 0);
        chk("dup_final", reg_write_data, 64'hBBBB);

        repeat (3) tick();
        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
